// File: rtl/param_register_file_if.sv
// param_register_file_if: decode/writeback-facing bus of the register file.
//   WriteData/RD/RegWrite : write port (driven by the master)
//   RS1/RS2               : read addresses (driven by the master)
//   ReadData1/ReadData2   : combinational read data (driven by the slave)
//   Ready                 : initialisation complete (driven by the slave)
interface param_register_file_if #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
);
    logic [XLEN-1:0] WriteData;
    logic [AW-1:0]   RD;
    logic            RegWrite;
    logic [AW-1:0]   RS1;
    logic [AW-1:0]   RS2;
    logic [XLEN-1:0] ReadData1;
    logic [XLEN-1:0] ReadData2;
    logic            Ready;

    modport master (
        output WriteData, RD, RegWrite, RS1, RS2,
        input  ReadData1, ReadData2, Ready
    );

    modport slave (
        input  WriteData, RD, RegWrite, RS1, RS2,
        output ReadData1, ReadData2, Ready
    );
endinterface

// File: rtl/param_register_file.sv
// param_register_file: NREGS x XLEN register file, two combinational read
// ports, one synchronous write port, post-reset init sequencer, optional
// hardwired-zero register 0 and write-first bypass.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   rf    : slave side of param_register_file_if (write port, read ports, Ready)
module param_register_file #(
    parameter int XLEN      = 64,
    parameter int NREGS     = 32,
    parameter int INIT_MODE = 1,
    parameter int ZERO_REG  = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    param_register_file_if.slave  rf
);
    typedef enum logic {INIT, RUN} state_t;

    state_t          state;
    logic [AW-1:0]   cnt;
    logic            ready_q;
    logic [XLEN-1:0] mem [NREGS];

    // Outputs are only meaningful once init is done and reset is released.
    logic live;
    assign live = reset && (state == RUN);

    function automatic logic in_range(logic [AW-1:0] a);
        return 32'(a) < NREGS;
    endfunction

    function automatic logic is_zero_reg(logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    logic we;
    assign we = live && rf.RegWrite && in_range(rf.RD) && !is_zero_reg(rf.RD);

    // Init sequencer: walks cnt over every entry once, then hands over to RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= INIT;
            cnt     <= '0;
            ready_q <= 1'b0;
        end else if (state == INIT) begin
            if (32'(cnt) == NREGS - 1) begin
                state   <= RUN;
                ready_q <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Storage has no reset; the sequencer rewrites every entry instead.
    always_ff @(posedge clk) begin
        if (reset && state == INIT) begin
            mem[cnt] <= (INIT_MODE != 0) ? XLEN'(cnt) : '0;
        end else if (we) begin
            mem[rf.RD] <= rf.WriteData;
        end
    end

    function automatic logic [XLEN-1:0] read_port(logic [AW-1:0] rs);
        logic [XLEN-1:0] r;
        r = '0;
        if (live && in_range(rs) && !is_zero_reg(rs)) begin
            if (we && rf.RD == rs) r = rf.WriteData;
            else                   r = mem[rs];
        end
        return r;
    endfunction

    always_comb begin
        rf.ReadData1 = read_port(rf.RS1);
        rf.ReadData2 = read_port(rf.RS2);
    end

    assign rf.Ready = ready_q;
endmodule

// File: tb/tb_param_register_file.sv
module tb_param_register_file;
    logic clk;
    logic reset0;
    logic reset1;
    int   n_cmp;
    int   n_bad;

    param_register_file_if #(.XLEN(64), .NREGS(32)) if0 ();
    param_register_file_if #(.XLEN(32), .NREGS(20)) if1 ();

    param_register_file u0 (.clk(clk), .reset(reset0), .rf(if0.slave));

    param_register_file #(.XLEN(32), .NREGS(20), .INIT_MODE(0), .ZERO_REG(0))
        u1 (.clk(clk), .reset(reset1), .rf(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset0 = 1'b0;
        reset1 = 1'b0;
        if0.WriteData = '0; if0.RD = '0; if0.RegWrite = 1'b0; if0.RS1 = 5'd5; if0.RS2 = 5'd31;
        if1.WriteData = '0; if1.RD = '0; if1.RegWrite = 1'b0; if1.RS1 = '0; if1.RS2 = '0;
        #2;
        chk("rst_ready", {63'd0, if0.Ready}, 64'd0);
        chk("rst_rd1", if0.ReadData1, 64'd0);
        chk("rst_rd2", if0.ReadData2, 64'd0);

        // 1. init sequence, default parameters
        @(negedge clk);
        reset0 = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            edge1();
            if (k == 10) chk("init_rd1_zero", if0.ReadData1, 64'd0);
            if (k >= 30) chk($sformatf("init_ready_E%0d", k), {63'd0, if0.Ready}, {63'd0, k == 32});
        end
        chk("init_rs1_5", if0.ReadData1, 64'd5);
        chk("init_rs2_31", if0.ReadData2, 64'd31);

        // 2. write then read
        if0.RegWrite = 1'b1; if0.RD = 5'd7; if0.WriteData = 64'hDEAD_BEEF_0000_1234;
        edge1();
        if0.RegWrite = 1'b0; if0.RS1 = 5'd7;
        #1 chk("wr_rd7", if0.ReadData1, 64'hDEAD_BEEF_0000_1234);

        // 3. bypass
        if0.RegWrite = 1'b1; if0.RD = 5'd3; if0.WriteData = 64'hA5; if0.RS1 = 5'd3; if0.RS2 = 5'd4;
        #1 chk("byp_rd1", if0.ReadData1, 64'hA5);
        chk("byp_rd2", if0.ReadData2, 64'd4);
        edge1();
        if0.RegWrite = 1'b0;
        #1 chk("byp_stored", if0.ReadData1, 64'hA5);

        // back-to-back writes to one register, last one wins
        if0.RegWrite = 1'b1; if0.RD = 5'd8; if0.WriteData = 64'h111; if0.RS1 = 5'd8;
        edge1();
        if0.WriteData = 64'h222;
        edge1();
        if0.RegWrite = 1'b0;
        #1 chk("b2b_last", if0.ReadData1, 64'h222);

        // 4. zero register
        if0.RegWrite = 1'b1; if0.RD = 5'd0; if0.WriteData = 64'hFF; if0.RS1 = 5'd0;
        #1 chk("zr_pre", if0.ReadData1, 64'd0);
        edge1();
        if0.RegWrite = 1'b0;
        #1 chk("zr_post", if0.ReadData1, 64'd0);

        // 5. reset mid-operation, between edges
        if0.RS1 = 5'd7; if0.RS2 = 5'd9;
        #1 reset0 = 1'b0;
        #1 chk("mid_rst_ready", {63'd0, if0.Ready}, 64'd0);
        chk("mid_rst_rd1", if0.ReadData1, 64'd0);
        chk("mid_rst_rd2", if0.ReadData2, 64'd0);
        if0.RegWrite = 1'b1; if0.RD = 5'd9; if0.WriteData = 64'h55;
        @(negedge clk);
        reset0 = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            edge1();
            if (k >= 31) chk($sformatf("reinit_ready_E%0d", k), {63'd0, if0.Ready}, {63'd0, k == 32});
        end
        if0.RegWrite = 1'b0;
        #1 chk("reinit_rs1_7", if0.ReadData1, 64'd7);
        chk("reinit_rs2_9", if0.ReadData2, 64'd9);

        // 6. alternate parameters
        @(negedge clk);
        reset1 = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            edge1();
            if (k >= 19) chk($sformatf("alt_ready_E%0d", k), {63'd0, if1.Ready}, {63'd0, k == 20});
        end
        for (int i = 0; i < 20; i++) begin
            if1.RS1 = 5'(i);
            #1 chk($sformatf("alt_init_%0d", i), {32'd0, if1.ReadData1}, 64'd0);
        end
        if1.RS1 = 5'd25;
        #1 chk("alt_oor_rd", {32'd0, if1.ReadData1}, 64'd0);
        if1.RegWrite = 1'b1; if1.RD = 5'd0; if1.WriteData = 32'h1;
        edge1();
        if1.RegWrite = 1'b0; if1.RS1 = 5'd0;
        #1 chk("alt_r0_write", {32'd0, if1.ReadData1}, 64'd1);
        if1.RegWrite = 1'b1; if1.RD = 5'd21; if1.WriteData = 32'h2; if1.RS2 = 5'd21;
        #1 chk("alt_oor_nobyp", {32'd0, if1.ReadData2}, 64'd0);
        edge1();
        if1.RegWrite = 1'b0;
        for (int i = 1; i < 20; i++) begin
            if1.RS1 = 5'(i);
            #1 chk($sformatf("alt_after_oor_%0d", i), {32'd0, if1.ReadData1}, 64'd0);
        end
        if1.RS1 = 5'd0;
        #1 chk("alt_r0_kept", {32'd0, if1.ReadData1}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
